// File: rtl/stream_demux_1ton_pkg.sv
// routing_pkg: shared mode encoding, channel limit and pointer helper for the routing layer
package routing_pkg;
    typedef enum logic {DIRECTED = 1'b0, ROUND_ROBIN = 1'b1} demux_mode_t;
    localparam int MAX_DEMUX_OUT = 16;
    function automatic int wrap_inc(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/stream_demux_1ton_out_slot.sv
// demux_out_slot: one-entry output holding register with pass-through drain and reload
module demux_out_slot #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    // load wins over drain so a same-cycle drain and reload keeps the slot full
    always_comb begin
        valid_d = load ? 1'b1 : (valid_q && !out_ready ? 1'b1 : 1'b0);
        data_d = load ? in_data : data_q;
    end
    // slot state; data is kept after a drain rather than cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q <= data_d;
        end
    end
    assign out_valid = valid_q;
    assign out_data = data_q;
endmodule

// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: registered 1-to-N valid/ready demux with directed and round-robin routing
module stream_demux_1ton
    import routing_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int NUM_OUT = 4,
    localparam int SEL_W = $clog2(NUM_OUT),
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] out_data [NUM_OUT],
    output logic [NUM_OUT-1:0]   out_valid,
    input  logic [NUM_OUT-1:0]   out_ready,
    output logic [SEL_W-1:0]     rr_ptr,
    output logic                 drop_pulse,
    output logic [CNT_W-1:0]     drop_count
);
    localparam int DEPTH = 1 << SEL_W;
    if (NUM_OUT < 2 || NUM_OUT > MAX_DEMUX_OUT) begin : g_bad_num_out
        $error("NUM_OUT out of range");
    end
    logic [SEL_W-1:0]   dest, rr_ptr_q, rr_ptr_d;
    logic [NUM_OUT-1:0] slot_free, load;
    logic [DEPTH-1:0]   free_map, range_map;
    logic               accept, drop, drop_pulse_q;
    logic [CNT_W-1:0]   drop_count_q, drop_count_d;
    assign slot_free = ~out_valid | out_ready;
    // select codes beyond NUM_OUT-1 are always ready and marked out of range
    for (genvar m = 0; m < DEPTH; m++) begin : g_map
        if (m < NUM_OUT) begin : g_in
            assign free_map[m] = slot_free[m];
            assign range_map[m] = 1'b1;
        end else begin : g_out
            assign free_map[m] = 1'b1;
            assign range_map[m] = 1'b0;
        end
    end
    // target select, handshake, strict-order pointer advance and saturating drop count
    always_comb begin
        dest = (demux_mode_t'(mode) == ROUND_ROBIN) ? rr_ptr_q : in_sel;
        in_ready = free_map[dest];
        accept = in_valid && in_ready;
        drop = accept && !range_map[dest];
        rr_ptr_d = (accept && demux_mode_t'(mode) == ROUND_ROBIN) ?
                   SEL_W'(wrap_inc(int'(rr_ptr_q), NUM_OUT)) : rr_ptr_q;
        drop_count_d = (drop && drop_count_q != '1) ? drop_count_q + 1'b1 : drop_count_q;
    end
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        assign load[k] = accept && (dest == SEL_W'(k));
        demux_out_slot #(.W(WORD_SIZE)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[k]),
            .in_data  (in_data),
            .out_ready(out_ready[k]),
            .out_valid(out_valid[k]),
            .out_data (out_data[k])
        );
    end
    // pointer and drop bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            drop_pulse_q <= drop;
            drop_count_q <= drop_count_d;
        end
    end
    assign rr_ptr = rr_ptr_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb_stream_demux_1ton: directed scenario tests for the 1-to-N stream demux
module tb_stream_demux_1ton;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;

    logic        mode4 = 1'b0, valid4 = 1'b0, ready4, dp4;
    logic [15:0] data4 = '0;
    logic [1:0]  sel4 = '0, rr4;
    logic [15:0] odata4 [4];
    logic [3:0]  ovalid4, oready4 = 4'hF;
    logic [7:0]  dc4;

    logic        mode3 = 1'b0, valid3 = 1'b0, ready3, dp3;
    logic [15:0] data3 = '0;
    logic [1:0]  sel3 = '0, rr3;
    logic [15:0] odata3 [3];
    logic [2:0]  ovalid3, oready3 = 3'h7;
    logic [1:0]  dc3;

    stream_demux_1ton #(.WORD_SIZE(16), .NUM_OUT(4), .CNT_W(8)) u4 (
        .clk(clk), .reset(reset), .mode(mode4), .in_data(data4), .in_sel(sel4),
        .in_valid(valid4), .in_ready(ready4), .out_data(odata4), .out_valid(ovalid4),
        .out_ready(oready4), .rr_ptr(rr4), .drop_pulse(dp4), .drop_count(dc4)
    );
    stream_demux_1ton #(.WORD_SIZE(16), .NUM_OUT(3), .CNT_W(2)) u3 (
        .clk(clk), .reset(reset), .mode(mode3), .in_data(data3), .in_sel(sel3),
        .in_valid(valid3), .in_ready(ready3), .out_data(odata3), .out_valid(ovalid3),
        .out_ready(oready3), .rr_ptr(rr3), .drop_pulse(dp3), .drop_count(dc3)
    );

    task automatic test_reset;
        #1;
        checks++; if (ovalid4 !== 4'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0000", ovalid4); end
        checks++; if (rr4 !== 2'd0) begin errors++; $display("FAIL rst_rr got=%0d exp=0", rr4); end
        checks++; if (odata4[1] !== 16'h0) begin errors++; $display("FAIL rst_data got=%h exp=0000", odata4[1]); end
        checks++; if (dp4 !== 1'b0 || dc4 !== 8'd0) begin errors++; $display("FAIL rst_drop got=%b/%0d exp=0/0", dp4, dc4); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ovalid3 !== 3'b0 || dc3 !== 2'd0) begin errors++; $display("FAIL rst_u3 got=%b/%0d exp=000/0", ovalid3, dc3); end
    endtask

    task automatic test_directed;
        mode4 = 1'b0; oready4 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            data4 = 16'hA000 + 16'(i); sel4 = 2'(3 - i); valid4 = 1'b1;
            #1;
            checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL dir_ready%0d got=%b exp=1", i, ready4); end
            @(negedge clk);
            checks++; if (ovalid4 !== 4'(1 << (3 - i))) begin errors++; $display("FAIL dir_valid%0d got=%b exp=%b", i, ovalid4, 4'(1 << (3 - i))); end
            checks++; if (odata4[3 - i] !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL dir_data%0d got=%h exp=%h", i, odata4[3 - i], 16'hA000 + 16'(i)); end
        end
        valid4 = 1'b0;
        @(negedge clk);
        checks++; if (ovalid4 !== 4'b0) begin errors++; $display("FAIL dir_drain got=%b exp=0000", ovalid4); end
    endtask

    task automatic test_drain_reload;
        mode4 = 1'b0; oready4 = 4'hF; sel4 = 2'd1; data4 = 16'h1111; valid4 = 1'b1;
        @(negedge clk);
        data4 = 16'h1234;
        #1;
        checks++; if (ready4 !== 1'b1 || ovalid4[1] !== 1'b1) begin errors++; $display("FAIL dr_pre got=%b/%b exp=1/1", ready4, ovalid4[1]); end
        @(negedge clk);
        valid4 = 1'b0;
        checks++; if (ovalid4[1] !== 1'b1 || odata4[1] !== 16'h1234) begin errors++; $display("FAIL dr_reload got=%b/%h exp=1/1234", ovalid4[1], odata4[1]); end
        @(negedge clk);
        checks++; if (ovalid4 !== 4'b0) begin errors++; $display("FAIL dr_empty got=%b exp=0000", ovalid4); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_dest [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        mode4 = 1'b1; oready4 = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            data4 = 16'hB000 + 16'(i); valid4 = 1'b1;
            #1;
            checks++; if (ready4 !== 1'b1 || rr4 !== exp_dest[i]) begin errors++; $display("FAIL rr_pre%0d got=%b/%0d exp=1/%0d", i, ready4, rr4, exp_dest[i]); end
            @(negedge clk);
            checks++; if (ovalid4[exp_dest[i]] !== 1'b1 || odata4[exp_dest[i]] !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL rr_out%0d got=%b/%h exp=1/%h", i, ovalid4[exp_dest[i]], odata4[exp_dest[i]], 16'hB000 + 16'(i)); end
        end
        data4 = 16'hB006;
        #1;
        checks++; if (ready4 !== 1'b0 || rr4 !== exp_dest[6]) begin errors++; $display("FAIL rr_stall got=%b/%0d exp=0/2", ready4, rr4); end
        @(negedge clk);
        checks++; if (rr4 !== 2'd2 || odata4[2] !== 16'hB002 || ovalid4[2] !== 1'b1) begin errors++; $display("FAIL rr_hold got=%0d/%h/%b exp=2/b002/1", rr4, odata4[2], ovalid4[2]); end
        oready4 = 4'hF;
        #1;
        checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL rr_release got=%b exp=1", ready4); end
        @(negedge clk);
        valid4 = 1'b0;
        checks++; if (odata4[2] !== 16'hB006 || ovalid4 !== 4'b0100 || rr4 !== 2'd3) begin errors++; $display("FAIL rr_last got=%h/%b/%0d exp=b006/0100/3", odata4[2], ovalid4, rr4); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stream;
        mode4 = 1'b0; oready4 = 4'h0; valid4 = 1'b1;
        data4 = 16'hC000; sel4 = 2'd0;
        @(negedge clk);
        data4 = 16'hC002; sel4 = 2'd2;
        @(negedge clk);
        valid4 = 1'b0;
        checks++; if (ovalid4 !== 4'b0101 || rr4 !== 2'd3) begin errors++; $display("FAIL rm_pre got=%b/%0d exp=0101/3", ovalid4, rr4); end
        #2 reset = 1'b1;
        #1;
        checks++; if (ovalid4 !== 4'b0 || rr4 !== 2'd0) begin errors++; $display("FAIL rm_async got=%b/%0d exp=0000/0", ovalid4, rr4); end
        @(negedge clk);
        reset = 1'b0; mode4 = 1'b1; oready4 = 4'h0; data4 = 16'hC0FF; valid4 = 1'b1;
        @(negedge clk);
        valid4 = 1'b0;
        checks++; if (ovalid4 !== 4'b0001 || odata4[0] !== 16'hC0FF || rr4 !== 2'd1) begin errors++; $display("FAIL rm_first got=%b/%h/%0d exp=0001/c0ff/1", ovalid4, odata4[0], rr4); end
        oready4 = 4'hF;
        @(negedge clk);
    endtask

    task automatic test_mode_switch;
        mode4 = 1'b1; oready4 = 4'hF; data4 = 16'hD001; valid4 = 1'b1;
        @(negedge clk);
        checks++; if (rr4 !== 2'd2) begin errors++; $display("FAIL ms_rr2 got=%0d exp=2", rr4); end
        mode4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel4 = 2'(i * 3); data4 = 16'hD010 + 16'(i);
            @(negedge clk);
            checks++; if (rr4 !== 2'd2 || ovalid4 !== 4'(1 << ((i * 3) % 4))) begin errors++; $display("FAIL ms_dir%0d got=%0d/%b exp=2/%b", i, rr4, ovalid4, 4'(1 << ((i * 3) % 4))); end
        end
        mode4 = 1'b1; data4 = 16'hD0EE;
        @(negedge clk);
        valid4 = 1'b0;
        checks++; if (ovalid4 !== 4'b0100 || odata4[2] !== 16'hD0EE || rr4 !== 2'd3) begin errors++; $display("FAIL ms_back got=%b/%h/%0d exp=0100/d0ee/3", ovalid4, odata4[2], rr4); end
        @(negedge clk);
    endtask

    task automatic test_drop;
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        mode3 = 1'b0; oready3 = 3'h0; sel3 = 2'd3; valid3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data3 = 16'hE000 + 16'(i);
            #1;
            checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL drop_ready%0d got=%b exp=1", i, ready3); end
            @(negedge clk);
            checks++; if (dp3 !== 1'b1 || dc3 !== exp_cnt[i] || ovalid3 !== 3'b0) begin errors++; $display("FAIL drop%0d got=%b/%0d/%b exp=1/%0d/000", i, dp3, dc3, ovalid3, exp_cnt[i]); end
        end
        sel3 = 2'd2; data3 = 16'hE0AA;
        @(negedge clk);
        valid3 = 1'b0;
        checks++; if (dp3 !== 1'b0 || dc3 !== 2'd3 || ovalid3 !== 3'b100 || odata3[2] !== 16'hE0AA) begin errors++; $display("FAIL drop_inrange got=%b/%0d/%b/%h exp=0/3/100/e0aa", dp3, dc3, ovalid3, odata3[2]); end
        mode3 = 1'b1; oready3 = 3'h7; valid3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (rr3 !== 2'(i % 3)) begin errors++; $display("FAIL rr3_wrap%0d got=%0d exp=%0d", i, rr3, i % 3); end
            @(negedge clk);
        end
        valid3 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_drain_reload;
        test_round_robin;
        test_reset_mid_stream;
        test_mode_switch;
        test_drop;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
